hash_tte_lookup: RTL and testbench

HASH_TTE_LOOKUP -- requirements
Module: hash_tte_lookup

---
 rtl/hash_tte_lookup.sv | 155 +++++++++++++++
 tb/tb_hash_tte_lookup.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hash_tte_lookup.sv
// TTE lookup stage: folds the MAC pair into a 12-bit bucket address and runs one
// request/response exchange with the bucket. The exchange is bounded by a timeout,
// and multicast destinations skip the bucket entirely.
module hash_tte_lookup #(
    parameter logic [12:0] TIMEOUT      = 13'd8000,
    parameter logic [15:0] MISS_PORTMAP = 16'h0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        hdr_valid,
    input  logic [47:0] hdr_dmac,
    input  logic [47:0] hdr_smac,
    output logic        hdr_ready,
    output logic        se_req,
    output logic [11:0] se_hash,
    output logic [47:0] se_dmac,
    output logic [47:0] se_smac,
    input  logic        se_ack,
    input  logic        se_nak,
    input  logic [15:0] se_result,
    output logic        res_valid,
    input  logic        res_ready,
    output logic        res_hit,
    output logic        res_timeout,
    output logic [15:0] res_portmap
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HASH = 2'd1,
        REQ  = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t      state_reg;
    logic        hdr_ready_reg;
    logic        se_req_reg;
    logic [11:0] se_hash_reg;
    logic [47:0] se_dmac_reg;
    logic [47:0] se_smac_reg;
    logic        res_valid_reg;
    logic        res_hit_reg;
    logic        res_timeout_reg;
    logic [15:0] res_portmap_reg;
    logic [12:0] wait_cnt_reg;

    // Per-slice XOR of the two keys; the four slices are then folded together.
    logic [47:0] slice_xor;
    logic [11:0] hash_next;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_slice
            assign slice_xor[12*gi +: 12] = se_dmac_reg[12*gi +: 12] ^ se_smac_reg[12*gi +: 12];
        end
    endgenerate

    assign hash_next = slice_xor[11:0] ^ slice_xor[23:12] ^ slice_xor[35:24] ^ slice_xor[47:36];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg       <= IDLE;
            hdr_ready_reg   <= 1'b0;
            se_req_reg      <= 1'b0;
            se_hash_reg     <= 12'h000;
            se_dmac_reg     <= 48'h0;
            se_smac_reg     <= 48'h0;
            res_valid_reg   <= 1'b0;
            res_hit_reg     <= 1'b0;
            res_timeout_reg <= 1'b0;
            res_portmap_reg <= 16'h0000;
            wait_cnt_reg    <= 13'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (hdr_valid && hdr_ready_reg) begin
                        hdr_ready_reg <= 1'b0;
                        se_dmac_reg   <= hdr_dmac;
                        se_smac_reg   <= hdr_smac;
                        state_reg     <= HASH;
                    end else begin
                        hdr_ready_reg <= 1'b1;
                    end
                end

                HASH: begin
                    se_hash_reg <= hash_next;
                    // Group bit set: never forwarded to the bucket.
                    if (se_dmac_reg[40]) begin
                        res_valid_reg   <= 1'b1;
                        res_hit_reg     <= 1'b0;
                        res_timeout_reg <= 1'b0;
                        res_portmap_reg <= MISS_PORTMAP;
                        state_reg       <= RESP;
                    end else begin
                        se_req_reg   <= 1'b1;
                        wait_cnt_reg <= 13'd0;
                        state_reg    <= REQ;
                    end
                end

                REQ: begin
                    if (se_ack) begin
                        se_req_reg      <= 1'b0;
                        res_valid_reg   <= 1'b1;
                        res_hit_reg     <= 1'b1;
                        res_timeout_reg <= 1'b0;
                        res_portmap_reg <= se_result;
                        state_reg       <= RESP;
                    end else if (se_nak) begin
                        se_req_reg      <= 1'b0;
                        res_valid_reg   <= 1'b1;
                        res_hit_reg     <= 1'b0;
                        res_timeout_reg <= 1'b0;
                        res_portmap_reg <= MISS_PORTMAP;
                        state_reg       <= RESP;
                    end else if (wait_cnt_reg == TIMEOUT - 13'd1) begin
                        // This is the last REQ cycle, so the request is held for exactly TIMEOUT cycles.
                        se_req_reg      <= 1'b0;
                        res_valid_reg   <= 1'b1;
                        res_hit_reg     <= 1'b0;
                        res_timeout_reg <= 1'b1;
                        res_portmap_reg <= MISS_PORTMAP;
                        state_reg       <= RESP;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 13'd1;
                    end
                end

                RESP: begin
                    if (res_ready) begin
                        res_valid_reg <= 1'b0;
                        hdr_ready_reg <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign hdr_ready   = hdr_ready_reg;
    assign se_req      = se_req_reg;
    assign se_hash     = se_hash_reg;
    assign se_dmac     = se_dmac_reg;
    assign se_smac     = se_smac_reg;
    assign res_valid   = res_valid_reg;
    assign res_hit     = res_hit_reg;
    assign res_timeout = res_timeout_reg;
    assign res_portmap = res_portmap_reg;

endmodule

// File: tb/tb_hash_tte_lookup.sv
// Scoreboard bench for hash_tte_lookup. Expected results are queued when a header is sent
// and compared at each result handshake; the bucket responses are driven inline.
module tb_hash_tte_lookup;

    localparam logic [12:0] TIMEOUT = 13'd8000;
    localparam logic [15:0] MISS    = 16'h0000;

    logic        clk;
    logic        rstn;
    logic        hdr_valid;
    logic [47:0] hdr_dmac;
    logic [47:0] hdr_smac;
    logic        hdr_ready;
    logic        se_req;
    logic [11:0] se_hash;
    logic [47:0] se_dmac;
    logic [47:0] se_smac;
    logic        se_ack;
    logic        se_nak;
    logic [15:0] se_result;
    logic        res_valid;
    logic        res_ready;
    logic        res_hit;
    logic        res_timeout;
    logic [15:0] res_portmap;

    hash_tte_lookup #(
        .TIMEOUT     (TIMEOUT),
        .MISS_PORTMAP(MISS)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .hdr_valid  (hdr_valid),
        .hdr_dmac   (hdr_dmac),
        .hdr_smac   (hdr_smac),
        .hdr_ready  (hdr_ready),
        .se_req     (se_req),
        .se_hash    (se_hash),
        .se_dmac    (se_dmac),
        .se_smac    (se_smac),
        .se_ack     (se_ack),
        .se_nak     (se_nak),
        .se_result  (se_result),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_hit    (res_hit),
        .res_timeout(res_timeout),
        .res_portmap(res_portmap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        hit;
        logic        tmo;
        logic [15:0] pm;
    } res_t;

    res_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    function automatic logic [11:0] hash_model(input logic [47:0] d, input logic [47:0] s);
        logic [11:0] h;
        logic [95:0] both;
        h    = 12'h000;
        both = {d, s};
        for (int k = 0; k < 8; k++) h = h ^ both[12*k +: 12];
        return h;
    endfunction

    // Result monitor: one pop per handshake.
    res_t got_r;
    res_t exp_r;
    always @(negedge clk) begin
        if (rstn && res_valid && res_ready) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_underflow", 64'(sb_q.size()), 64'd1);
            end else begin
                exp_r = sb_q.pop_front();
                got_r.hit = res_hit;
                got_r.tmo = res_timeout;
                got_r.pm  = res_portmap;
                check_eq("res_hit", 64'(got_r.hit), 64'(exp_r.hit));
                check_eq("res_timeout", 64'(got_r.tmo), 64'(exp_r.tmo));
                check_eq("res_portmap", 64'(got_r.pm), 64'(exp_r.pm));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic hit, input logic tmo, input logic [15:0] pm);
        res_t e;
        e.hit = hit;
        e.tmo = tmo;
        e.pm  = pm;
        sb_q.push_back(e);
    endtask

    task automatic send_hdr(input string tag, input logic [47:0] d, input logic [47:0] s);
        check_eq({tag, "_ready_before"}, 64'(hdr_ready), 64'd1);
        hdr_dmac  = d;
        hdr_smac  = s;
        hdr_valid = 1'b1;
        tick();
        hdr_valid = 1'b0;
        check_eq({tag, "_ready_after"}, 64'(hdr_ready), 64'd0);
    endtask

    task automatic wait_req(output int n);
        n = 0;
        while (!se_req && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic finish_handshake(input string tag);
        tick();
        check_eq({tag, "_ready_next"}, 64'(hdr_ready), 64'd1);
        check_eq({tag, "_valid_drop"}, 64'(res_valid), 64'd0);
    endtask

    // mode: 0 = ack, 1 = nak, 2 = ack and nak together
    task automatic unicast(input string tag, input logic [47:0] d, input logic [47:0] s,
                           input int mode, input int delay, input logic [15:0] result);
        int   n;
        logic held;
        if (mode == 1) push_exp(1'b0, 1'b0, MISS);
        else           push_exp(1'b1, 1'b0, result);
        send_hdr(tag, d, s);
        wait_req(n);
        check_eq({tag, "_req_lat"}, 64'(n), 64'd1);
        check_eq({tag, "_hash"}, 64'(se_hash), 64'(hash_model(d, s)));
        check_eq({tag, "_keys"}, {16'h0, se_dmac ^ se_smac}, {16'h0, d ^ s});
        held = 1'b1;
        for (int i = 1; i < delay; i++) begin
            tick();
            held = held & se_req & (se_hash == hash_model(d, s)) & !res_valid;
        end
        check_eq({tag, "_req_held"}, 64'(held), 64'd1);
        se_ack    = (mode != 1);
        se_nak    = (mode != 0);
        se_result = result;
        tick();
        se_ack    = 1'b0;
        se_nak    = 1'b0;
        se_result = 16'hdead;
        check_eq({tag, "_req_drop"}, 64'(se_req), 64'd0);
        check_eq({tag, "_res_lat"}, 64'(res_valid), 64'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          n;
        logic        ok;
        logic [15:0] pm_hold;
        logic [47:0] rd;
        logic [47:0] rs;

        rstn      = 1'b0;
        hdr_valid = 1'b0;
        hdr_dmac  = 48'h0;
        hdr_smac  = 48'h0;
        se_ack    = 1'b0;
        se_nak    = 1'b0;
        se_result = 16'h0;
        res_ready = 1'b1;
        repeat (3) tick();
        check_eq("rst_hdr_ready", 64'(hdr_ready), 64'd0);
        check_eq("rst_se_req", 64'(se_req), 64'd0);
        check_eq("rst_res_flags", {61'h0, res_valid, res_hit, res_timeout}, 64'd0);
        check_eq("rst_se_hash", 64'(se_hash), 64'd0);
        check_eq("rst_portmap", 64'(res_portmap), 64'd0);
        check_eq("rst_keys", {16'h0, se_dmac | se_smac}, 64'd0);
        rstn = 1'b1;
        tick();
        check_eq("rel_hdr_ready", 64'(hdr_ready), 64'd1);

        // Hit: reference vector, ack after 5 cycles
        unicast("hit", 48'h60beb403060e, 48'h60beb403644d, 0, 5, 16'h0002);
        check_eq("hit_hash_const", 64'(se_hash), 64'h245);
        finish_handshake("hit");

        // Miss
        unicast("miss", 48'h60beb4030611, 48'h60beb4037722, 1, 3, 16'hbeef);
        finish_handshake("miss");

        // Ack and nak together: ack wins
        unicast("both", 48'h0a0b0c0d0e0f, 48'h112233445566, 2, 2, 16'h00f3);
        finish_handshake("both");

        // Multicast bypass
        push_exp(1'b0, 1'b0, MISS);
        send_hdr("mcast", 48'h01005e000001, 48'h60beb403644d);
        check_eq("mcast_valid_early", 64'(res_valid), 64'd0);
        tick();
        check_eq("mcast_valid_2cyc", 64'(res_valid), 64'd1);
        check_eq("mcast_no_req", 64'(se_req), 64'd0);
        finish_handshake("mcast");

        // Backpressure
        res_ready = 1'b0;
        unicast("bp", 48'h3c0000abcdef, 48'h7e0000123456, 0, 2, 16'h5a5a);
        pm_hold = res_portmap;
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            ok = ok & res_valid & res_hit & !res_timeout & (res_portmap == pm_hold) & !hdr_ready;
        end
        check_eq("bp_stable", 64'(ok), 64'd1);
        check_eq("bp_portmap", 64'(pm_hold), 64'h5a5a);
        res_ready = 1'b1;
        finish_handshake("bp");

        // Timeout, then stray acks that must be ignored
        push_exp(1'b0, 1'b1, MISS);
        send_hdr("tmo", 48'h001122334455, 48'h66778899aabb);
        wait_req(n);
        check_eq("tmo_req_lat", 64'(n), 64'd1);
        n = 0;
        while (se_req && n < int'(TIMEOUT) + 10) begin
            n++;
            tick();
        end
        check_eq("tmo_req_cycles", 64'(n), 64'(TIMEOUT));
        check_eq("tmo_valid", 64'(res_valid), 64'd1);
        se_ack    = 1'b1;
        se_result = 16'hffff;
        tick();
        se_ack = 1'b0;
        check_eq("tmo_ready_next", 64'(hdr_ready), 64'd1);
        se_ack = 1'b1;
        tick();
        se_ack = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            ok = ok & !res_valid & !se_req & hdr_ready;
        end
        check_eq("stray_ignored", 64'(ok), 64'd1);

        // Next lookup after timeout completes normally
        unicast("post_tmo", 48'h60beb403060e, 48'h60beb403644d, 0, 1, 16'h0010);
        finish_handshake("post_tmo");

        // Reset in the middle of a request
        push_exp(1'b1, 1'b0, 16'h0);
        send_hdr("rst", 48'h2468ace02468, 48'h13579bdf1357);
        wait_req(n);
        check_eq("rst_req_up", 64'(se_req), 64'd1);
        rstn = 1'b0;
        #1;
        check_eq("rst_req_async", 64'(se_req), 64'd0);
        check_eq("rst_ready_low", 64'(hdr_ready), 64'd0);
        void'(sb_q.pop_back());
        tick();
        tick();
        rstn      = 1'b1;
        se_ack    = 1'b1;
        se_result = 16'h0077;
        tick();
        se_ack = 1'b0;
        check_eq("rst_idle_ready", 64'(hdr_ready), 64'd1);
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            ok = ok & !res_valid & !se_req;
        end
        check_eq("rst_no_result", 64'(ok), 64'd1);

        // A few pseudo-random unicast lookups
        for (int t = 0; t < 4; t++) begin
            rd = {$urandom, $urandom};
            rs = {$urandom, $urandom};
            rd[40] = 1'b0;
            unicast("rnd", rd, rs, t % 3, 1 + (t * 2), 16'($urandom));
            finish_handshake("rnd");
        end

        check_eq("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
